uart_loopback_tester: RTL and testbench
=======================================

Name: uart_loopback_tester

Overview:
- Parametrised self-checking UART test-pattern engine.
- Sends NUM_SYM symbols one at a time to the UART transmitter and waits for each to return through the receiver (external loopback).
- Compares each returned word against the word sent, then reports error count, timeout and pass/fail.
- Sits between the UART tx/rx pair and the board-level status LEDs/registers; successor to the fixed four-symbol data generator.

Parameters:
- DATA_W, 8, symbol width in bits (5..16).
- NUM_SYM, 4, symbols per run (1..65535).
- SEED, 8'hAA (zero-extended to DATA_W), first symbol / LFSR seed.
- TIMEOUT_TICKS, 4096, tick_en pulses allowed per symbol before abort.
- CNT_W, 16, width of err_count and sym_count.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, begin a run
- tick_en  in  1  baud sample-enable pulse, one clk wide
- tx_busy  in  1  transmitter busy
- rx_valid  in  1  one-clk pulse, rx_data valid
- rx_data  in  DATA_W  received word
- tx_en  out  1  transmitter enable
- rx_en  out  1  receiver enable
- tx_wr  out  1  one-clk write strobe
- tx_data  out  DATA_W  word to transmit, held stable while tx_wr=1
- busy  out  1  run in progress
- done  out  1  run finished, held until next start
- pass  out  1  valid when done=1
- timeout  out  1  run aborted on timeout
- err_count  out  CNT_W  mismatched symbols
- sym_count  out  CNT_W  symbols completed

Behaviour:
- All outputs are registered on clk; reset is asynchronous.
- Reset values: tx_en=1, rx_en=1; all other outputs 0; state=IDLE.
- States:
  - IDLE: on start -> LOAD; sym_count, err_count, timeout and done cleared; pattern generator reloaded with SEED.
  - LOAD: when tx_busy=0, drive tx_data=current pattern, tx_wr=1 for exactly one clk, latch expected=tx_data, clear the timeout counter -> WAIT_RX. While tx_busy=1, hold with tx_wr=0.
  - WAIT_RX: rx_valid=1 -> CHECK, rx_data captured that cycle. Each tick_en increments the timeout counter; on reaching TIMEOUT_TICKS -> DONE with timeout=1.
  - CHECK (one clk): if rx_data != expected, err_count+1 (saturates at all-ones); sym_count+1; pattern advances. If sym_count+1 == NUM_SYM -> DONE, else -> LOAD.
  - DONE: done=1, busy=0, pass=(err_count==0 && !timeout). A new start -> IDLE actions, then LOAD on the next clk.
- busy=1 in LOAD, WAIT_RX and CHECK.
- Baseline pattern: sym_k = (SEED + k) mod 2^DATA_W; wraps naturally.
- Latency:
  - start to first tx_wr: 1 clk if tx_busy=0.
  - rx_valid to next tx_wr: 2 clk (CHECK, LOAD) if tx_busy=0.
- Boundary conditions:
  - start while busy=1: ignored.
  - rx_valid outside WAIT_RX: ignored; it is not counted as an error.
  - rx_valid and the final tick in the same cycle: rx_valid wins, no timeout.
  - Reset mid-run: immediate return to IDLE with reset values; no partial results retained.
  - NUM_SYM=1: DONE directly after the first CHECK.

Optional Feature:
- Macro: UART_LBT_PRBS_EN.
- Defined: the pattern is a Fibonacci LFSR of DATA_W bits. Taps come from a package function indexed by DATA_W (maximal length, e.g. x^8+x^6+x^5+x^4+1 for 8). Seeded with SEED; a SEED of 0 is forced to 1. Shifted once per CHECK.
- Undefined: the incrementing pattern above; no LFSR logic is synthesised.

Decomposition:
- Package uart_lbt_pkg:
  - state enum (IDLE, LOAD, WAIT_RX, CHECK, DONE)
  - lfsr_taps(width) function
  - default constants
- Sub-module uart_lbt_pattern:
  - ports clk, reset, load, advance, seed
  - output current symbol
  - contains the incrementing or LFSR generator, selected by the macro

Test Plan:
- Clean loopback: rx_data mirrors tx_data after 10 ticks, NUM_SYM=4, SEED=8'hAA -> tx words AA,AB,AC,AD; done=1, pass=1, err_count=0, sym_count=4.
- Bit flip: third returned word XOR 8'h01 -> err_count=1, pass=0, sym_count=4.
- Lost symbol: no rx_valid after the second tx_wr, TIMEOUT_TICKS=16 -> after 16 tick_en pulses done=1, timeout=1, sym_count=1, pass=0.
- Busy stall: tx_busy held high 50 clk after start -> no tx_wr until tx_busy falls, then exactly one 1-clk tx_wr.
- Reset mid-run: assert reset during WAIT_RX of symbol 2 -> all outputs at reset values immediately. Next start restarts at SEED with counters at 0.
- UART_LBT_PRBS_EN, DATA_W=8, SEED=8'h01, NUM_SYM=255 -> 255 distinct nonzero words, no repeat, pass=1.

Source files
------------

// File: rtl/uart_lbt_pkg.sv
// Shared types and constants for the UART loopback tester: FSM state encoding,
// default parameter values and maximal-length LFSR tap masks.
package uart_lbt_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WAIT_RX = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam int unsigned DEF_DATA_W        = 8;
    localparam int unsigned DEF_NUM_SYM       = 4;
    localparam int unsigned DEF_SEED          = 'hAA;
    localparam int unsigned DEF_TIMEOUT_TICKS = 4096;
    localparam int unsigned DEF_CNT_W         = 16;

    // Bit i set means stage i+1 feeds the XOR; each mask gives a maximal-length sequence.
    function automatic logic [15:0] lfsr_taps(input int unsigned width);
        logic [15:0] taps;
        case (width)
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h00B8;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/uart_lbt_if.sv
// UART-side connection of the loopback tester: transmit handshake, receive strobe
// and baud tick. master = tester, slave = UART tx/rx pair.
interface uart_lbt_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              tick_en;
    logic              tx_busy;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              tx_en;
    logic              rx_en;
    logic              tx_wr;
    logic [DATA_W-1:0] tx_data;

    modport master (
        input  tick_en, tx_busy, rx_valid, rx_data,
        output tx_en, rx_en, tx_wr, tx_data
    );

    modport slave (
        output tick_en, tx_busy, rx_valid, rx_data,
        input  tx_en, rx_en, tx_wr, tx_data
    );
endinterface

// File: rtl/uart_lbt_pattern.sv
// Test-pattern source: incrementing counter, or a Fibonacci LFSR when
// UART_LBT_PRBS_EN is defined. load reseeds, advance steps once.
module uart_lbt_pattern
    import uart_lbt_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] sym_o
);

    logic [DATA_W-1:0] sym_q;
    logic [DATA_W-1:0] sym_d;

`ifdef UART_LBT_PRBS_EN
    localparam logic [15:0]       TAPS16 = lfsr_taps(DATA_W);
    localparam logic [DATA_W-1:0] TAPS   = TAPS16[DATA_W-1:0];

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    always_comb begin
        sym_d = sym_q;
        if (load)
            sym_d = (seed == '0) ? DATA_W'(1) : seed;
        else if (advance)
            sym_d = {sym_q[DATA_W-2:0], ^(sym_q & TAPS)};
    end
`else
    always_comb begin
        sym_d = sym_q;
        if (load)
            sym_d = seed;
        else if (advance)
            sym_d = sym_q + DATA_W'(1);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sym_q <= '0;
        else
            sym_q <= sym_d;
    end

    assign sym_o = sym_q;

endmodule

// File: rtl/uart_loopback_tester.sv
// Self-checking UART loopback engine: sends NUM_SYM symbols one by one, compares each
// echoed word, reports errors/timeout/pass. Define UART_LBT_PRBS_EN for an LFSR pattern.
module uart_loopback_tester
    import uart_lbt_pkg::*;
#(
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned NUM_SYM       = DEF_NUM_SYM,
    parameter int unsigned SEED          = DEF_SEED,
    parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    uart_lbt_if.master       uart,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sym_count
);

    localparam logic [DATA_W-1:0] SEED_W = DATA_W'(SEED);
    localparam int unsigned       TMO_W  = $clog2(TIMEOUT_TICKS + 1);

    state_e            state_q;
    logic              tx_en_q, rx_en_q, tx_wr_q;
    logic [DATA_W-1:0] tx_data_q, exp_q, rx_q;
    logic              busy_q, done_q, pass_q, timeout_q;
    logic [CNT_W-1:0]  err_q, sym_q;
    logic [TMO_W-1:0]  tmo_q;

    logic              pat_load, pat_adv;
    logic [DATA_W-1:0] pat_sym;
    logic [CNT_W-1:0]  err_d, sym_d;
    logic              last_sym, last_tick;

    uart_lbt_pattern #(.DATA_W(DATA_W)) u_pattern (
        .clk     (clk),
        .reset   (reset),
        .load    (pat_load),
        .advance (pat_adv),
        .seed    (SEED_W),
        .sym_o   (pat_sym)
    );

    always_comb begin
        pat_load  = start && (state_q == IDLE || state_q == DONE);
        pat_adv   = (state_q == CHECK);
        err_d     = err_q;
        if (rx_q != exp_q && err_q != '1)
            err_d = err_q + CNT_W'(1);
        sym_d     = sym_q + CNT_W'(1);
        last_sym  = (32'(sym_q) + 32'd1) == NUM_SYM;
        last_tick = (32'(tmo_q) + 32'd1) >= TIMEOUT_TICKS;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_en_q   <= 1'b1;
            rx_en_q   <= 1'b1;
            tx_wr_q   <= 1'b0;
            tx_data_q <= '0;
            exp_q     <= '0;
            rx_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            sym_q     <= '0;
            tmo_q     <= '0;
        end else begin
            tx_wr_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= LOAD;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        err_q     <= '0;
                        sym_q     <= '0;
                    end
                end
                LOAD: begin
                    if (!uart.tx_busy) begin
                        tx_wr_q   <= 1'b1;
                        tx_data_q <= pat_sym;
                        exp_q     <= pat_sym;
                        tmo_q     <= '0;
                        state_q   <= WAIT_RX;
                    end
                end
                WAIT_RX: begin
                    // A word arriving together with the final tick still counts.
                    if (uart.rx_valid) begin
                        rx_q    <= uart.rx_data;
                        state_q <= CHECK;
                    end else if (uart.tick_en) begin
                        if (last_tick) begin
                            state_q   <= DONE;
                            timeout_q <= 1'b1;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            pass_q    <= 1'b0;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                end
                CHECK: begin
                    err_q <= err_d;
                    sym_q <= sym_d;
                    if (last_sym) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= (err_d == '0) && !timeout_q;
                    end else begin
                        state_q <= LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign uart.tx_en   = tx_en_q;
    assign uart.rx_en   = rx_en_q;
    assign uart.tx_wr   = tx_wr_q;
    assign uart.tx_data = tx_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout      = timeout_q;
    assign err_count    = err_q;
    assign sym_count    = sym_q;

endmodule

// File: tb/tb_uart_loopback_tester.sv
// Randomized loopback bench for uart_loopback_tester (NUM_SYM=4, SEED=AA, TIMEOUT_TICKS=16).
// Pattern expectations follow UART_LBT_PRBS_EN when it is defined.
module tb_uart_loopback_tester;

    localparam int NSYM = 4;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count, sym_count;

    int n_cmp = 0;
    int n_bad = 0;

    uart_lbt_if #(.DATA_W(8)) uif ();

    uart_loopback_tester #(
        .DATA_W(8), .NUM_SYM(NSYM), .SEED('hAA), .TIMEOUT_TICKS(TMO), .CNT_W(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .uart      (uif.master),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .err_count (err_count),
        .sym_count (sym_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tx_en"}, uif.tx_en, 1);
        check_eq({tag, "_rx_en"}, uif.rx_en, 1);
        check_eq({tag, "_tx_wr"}, uif.tx_wr, 0);
        check_eq({tag, "_tx_data"}, uif.tx_data, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_pass"}, pass, 0);
        check_eq({tag, "_timeout"}, timeout, 0);
        check_eq({tag, "_err"}, err_count, 0);
        check_eq({tag, "_sym"}, sym_count, 0);
    endtask

    // One run with a behavioural UART echo. drop_idx withholds that symbol's echo
    // (race: deliver it on the same cycle as the final tick); reset_at aborts the run.
    task automatic run_case(input string tag, input int stall, input logic [3:0] flip,
                            input int drop_idx, input bit race, input bit spur_start,
                            input int reset_at);
        int         k, pend, ticks, exp_sym, exp_err, stall_wr;
        bit         prev_wr, waiting_drop, finished, exp_tmo;
        logic [7:0] w, exp_w, pend_word;
        logic [7:0] seen[$];
        k = 0; pend = -1; ticks = 0; exp_sym = 0; exp_err = 0; stall_wr = 0;
        prev_wr = 0; waiting_drop = 0; finished = 0; exp_tmo = 0;
        seen.delete();

        @(negedge clk);
        start = 1'b1;
        uif.tx_busy = (stall > 0);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (done) begin
                finished = 1;
                break;
            end
            if (uif.tx_wr) begin
                if (prev_wr) begin
                    check_eq({tag, "_wr_width"}, 32'(prev_wr), 0);
                end else begin
                    w = uif.tx_data;
                    if (cyc <= stall) stall_wr++;
                    check_eq({tag, "_busy_run"}, busy, 1);
`ifdef UART_LBT_PRBS_EN
                    check_eq({tag, "_prbs_nz"}, 32'(w != 0), 1);
                    foreach (seen[i]) if (seen[i] == w) check_eq({tag, "_prbs_rep"}, w, ~w);
                    seen.push_back(w);
`else
                    exp_w = 8'hAA + 8'(k);
                    check_eq({tag, "_word"}, w, exp_w);
`endif
                    if (k == reset_at) begin
                        uif.rx_valid = 1'b0;
                        uif.tick_en  = 1'b0;
                        reset = 1'b1;
                        #1;
                        check_reset_outputs({tag, "_rst"});
                        @(negedge clk);
                        reset = 1'b0;
                        return;
                    end
                    if (k == drop_idx) begin
                        waiting_drop = 1;
                        ticks = 0;
                    end else begin
                        pend = int'($urandom_range(2, 9));
                        pend_word = w;
                        if (flip[k]) pend_word = w ^ (8'h01 << $urandom_range(0, 7));
                    end
                    k++;
                end
            end
            prev_wr = uif.tx_wr;

            start = 1'b0;
            uif.rx_valid = 1'b0;
            uif.tx_busy  = (cyc < stall);
            uif.tick_en  = (cyc % 3 == 2);
            if (stall >= 4 && cyc == 2) begin
                uif.rx_valid = 1'b1;
                uif.rx_data  = 8'h33;
            end
            if (spur_start && k == 3 && pend == 2) start = 1'b1;
            if (waiting_drop && uif.tick_en) begin
                ticks++;
                if (race && ticks == TMO) begin
                    uif.rx_valid = 1'b1;
                    uif.rx_data  = w;
                    waiting_drop = 0;
                    exp_sym++;
                end
            end
            if (pend > 0) begin
                pend--;
            end else if (pend == 0) begin
                uif.rx_valid = 1'b1;
                uif.rx_data  = pend_word;
                if (pend_word != w) exp_err++;
                exp_sym++;
                pend = -1;
            end
            @(negedge clk);
        end

        check_eq({tag, "_finished"}, 32'(finished), 1);
        exp_tmo = (drop_idx >= 0) && !race;
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_busy_done"}, busy, 0);
        check_eq({tag, "_timeout"}, timeout, 32'(exp_tmo));
        check_eq({tag, "_sym"}, sym_count, exp_sym);
        check_eq({tag, "_err"}, err_count, exp_err);
        check_eq({tag, "_pass"}, pass, 32'(exp_err == 0 && !exp_tmo));
        check_eq({tag, "_words"}, k, exp_tmo ? drop_idx + 1 : NSYM);
        if (stall > 0) check_eq({tag, "_stall_wr"}, stall_wr, 0);
        if (exp_tmo) check_eq({tag, "_ticks"}, ticks, TMO);

        uif.tick_en  = 1'b0;
        uif.rx_valid = 1'b1;
        uif.rx_data  = 8'h00;
        @(negedge clk);
        uif.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq({tag, "_hold_done"}, done, 1);
        check_eq({tag, "_hold_err"}, err_count, exp_err);
    endtask

    initial begin
        uif.tick_en  = 1'b0;
        uif.tx_busy  = 1'b0;
        uif.rx_valid = 1'b0;
        uif.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        run_case("clean",   0,  4'b0000, -1, 0, 0, -1);
        run_case("bitflip", 0,  4'b0100, -1, 0, 0, -1);
        run_case("stall",   50, 4'b0000, -1, 0, 0, -1);
        run_case("lost",    0,  4'b0000, 1,  0, 0, -1);
        run_case("race",    0,  4'b0000, 1,  1, 0, -1);
        run_case("restart", 0,  4'b0000, -1, 0, 1, -1);
        run_case("midrst",  0,  4'b0000, -1, 0, 0, 1);
        run_case("afterrst", 0, 4'b0000, -1, 0, 0, -1);
        for (int r = 0; r < 8; r++) begin
            run_case($sformatf("rand%0d", r), int'($urandom_range(0, 20)),
                     4'($urandom_range(0, 15)),
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
